// File: rtl/cov_array_feed_ctrl_if.sv
// cov_array_feed_ctrl_if: start/status, sample-buffer read port and skewed array feed
interface cov_array_feed_ctrl_if #(
    parameter int N_ANT        = 4,
    parameter int DATA_WIDTH   = 16,
    parameter int SAMPLES_BITS = 4
);
    logic                            start;
    logic                            busy;
    logic                            done;
    logic                            buf_rd_en;
    logic [SAMPLES_BITS-1:0]         buf_rd_addr;
    logic [N_ANT*2*DATA_WIDTH-1:0]   buf_rd_data;
    logic [N_ANT*DATA_WIDTH-1:0]     feed_q;
    logic [N_ANT*DATA_WIDTH-1:0]     feed_i;
    logic [N_ANT-1:0]                fin_lane;

    modport master (
        input  start, buf_rd_data,
        output busy, done, buf_rd_en, buf_rd_addr, feed_q, feed_i, fin_lane
    );

    modport slave (
        output start, buf_rd_data,
        input  busy, done, buf_rd_en, buf_rd_addr, feed_q, feed_i, fin_lane
    );
endinterface

// File: rtl/cov_array_feed_ctrl.sv
// cov_array_feed_ctrl: reads S snapshots and feeds a skewed, zero-filled stream into the covariance array
module cov_array_feed_ctrl #(
    parameter int N_ANT        = 4,
    parameter int DATA_WIDTH   = 16,
    parameter int SAMPLES_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cov_array_feed_ctrl_if.master bus
);
    localparam int S  = 1 << SAMPLES_BITS;
    localparam int DW = DATA_WIDTH;
    localparam int LW = 2 * DW;
    localparam int CW = $clog2(S + 2 * N_ANT + 2);
    localparam logic [CW-1:0] READ_END  = CW'(S - 1);
    localparam logic [CW-1:0] DRAIN_END = CW'(S + 2 * N_ANT - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           cnt;
    logic [SAMPLES_BITS-1:0] addr;
    logic                    vld;
    logic                    last;
    logic [N_ANT*LW-1:0]     lane0;
    logic [N_ANT*LW-1:0]     skewed;
    logic [N_ANT-2:0]        fin_d;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next state: cnt counts cycles from the first read, so it marks both the read and drain ends
    always_comb begin
        state_nxt = (state == IDLE  && bus.start)        ? READ  :
                    (state == READ  && cnt == READ_END)  ? DRAIN :
                    (state == DRAIN && cnt == DRAIN_END) ? DONE  :
                    (state == DONE)                      ? IDLE  : state;
    end

    // state-decoded outputs
    always_comb begin
        bus.busy        = (state == READ) || (state == DRAIN);
        bus.done        = (state == DONE);
        bus.buf_rd_en   = (state == READ);
        bus.buf_rd_addr = addr;
    end

    // run counter, read address (wraps to 0 after the last read) and returned-data tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            addr  <= '0;
            vld   <= 1'b0;
            last  <= 1'b0;
            fin_d <= '0;
        end else begin
            cnt   <= bus.busy ? cnt + 1'b1 : '0;
            addr  <= bus.buf_rd_en ? addr + 1'b1 : addr;
            vld   <= bus.buf_rd_en;
            last  <= bus.buf_rd_en && (addr == '1);
            fin_d <= bus.fin_lane[N_ANT-2:0];
        end
    end

    // lane 0 takes returned data directly; outside valid reads every lane sees zero
    always_comb begin
        lane0        = vld ? bus.buf_rd_data : '0;
        bus.fin_lane = {fin_d, last};
    end

    assign skewed[LW-1:0] = lane0[LW-1:0];

    for (genvar k = 1; k < N_ANT; k++) begin : g_skew
        logic [LW-1:0] sr [k];
        // k-stage delay line so lane k lags lane 0 by k cycles
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int j = 0; j < k; j++) sr[j] <= '0;
            end else begin
                sr[0] <= lane0[k*LW +: LW];
                for (int j = 1; j < k; j++) sr[j] <= sr[j-1];
            end
        end
        assign skewed[k*LW +: LW] = sr[k-1];
    end

    // split each skewed {q,i} lane onto the Q and I feed buses
    always_comb begin
        bus.feed_q = '0;
        bus.feed_i = '0;
        for (int k = 0; k < N_ANT; k++) begin
            bus.feed_q[k*DW +: DW] = skewed[k*LW + DW +: DW];
            bus.feed_i[k*DW +: DW] = skewed[k*LW +: DW];
        end
    end
endmodule

// File: tb/tb_cov_array_feed_ctrl.sv
// tb_cov_array_feed_ctrl: directed checks of the feed sequencer with a buffer and PE-array model
module tb_cov_array_feed_ctrl;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int SB = 4;
    localparam int S  = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   mode     = 0;

    always #5 clk = ~clk;

    cov_array_feed_ctrl_if #(.N_ANT(N), .DATA_WIDTH(DW), .SAMPLES_BITS(SB)) bus ();
    cov_array_feed_ctrl #(.N_ANT(N), .DATA_WIDTH(DW), .SAMPLES_BITS(SB)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    cov_array_feed_ctrl_if #(.N_ANT(2), .DATA_WIDTH(16), .SAMPLES_BITS(1)) bus2 ();
    cov_array_feed_ctrl #(.N_ANT(2), .DATA_WIDTH(16), .SAMPLES_BITS(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );

    function automatic logic [N*2*DW-1:0] word(int s);
        logic [N*2*DW-1:0] w;
        w = '0;
        for (int k = 0; k < N; k++) begin
            w[(2*k+1)*DW +: DW] = (mode != 0) ? DW'(k + 1) : DW'(16 * k + s);
            w[2*k*DW +: DW]     = (mode != 0) ? DW'(0)     : DW'(-(16 * k + s));
        end
        return w;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.buf_rd_data  <= '0;
            bus2.buf_rd_data <= '0;
        end else begin
            if (bus.buf_rd_en)  bus.buf_rd_data  <= word(int'(bus.buf_rd_addr));
            if (bus2.buf_rd_en) bus2.buf_rd_data <= {4{16'h1234}};
        end
    end

    logic signed [DW-1:0] a_q [N][N], a_i [N][N], b_q [N][N], b_i [N][N];
    logic                 a_f [N][N], p_f [N][N], res_v [N][N];
    logic signed [47:0]   p_q [N][N], p_i [N][N], acc_q [N][N], acc_i [N][N];
    logic signed [47:0]   res_q [N][N], res_i [N][N];

    always @(posedge clk or negedge rst_n) begin : pe_model
        logic signed [DW-1:0] aq, ai, bq, bi;
        logic f;
        int cm, rm;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (!rst_n) begin
                    a_q[r][c] <= '0; a_i[r][c] <= '0; b_q[r][c] <= '0; b_i[r][c] <= '0;
                    a_f[r][c] <= 1'b0; p_f[r][c] <= 1'b0; res_v[r][c] <= 1'b0;
                    p_q[r][c] <= '0; p_i[r][c] <= '0; acc_q[r][c] <= '0; acc_i[r][c] <= '0;
                    res_q[r][c] <= '0; res_i[r][c] <= '0;
                end else begin
                    cm = (c == 0) ? 0 : c - 1;
                    rm = (r == 0) ? 0 : r - 1;
                    aq = (c == 0) ? $signed(bus.feed_q[r*DW +: DW]) : a_q[r][cm];
                    ai = (c == 0) ? $signed(bus.feed_i[r*DW +: DW]) : a_i[r][cm];
                    f  = (c == 0) ? bus.fin_lane[r] : a_f[r][cm];
                    bq = (r == 0) ? $signed(bus.feed_q[c*DW +: DW]) : b_q[rm][c];
                    bi = (r == 0) ? $signed(bus.feed_i[c*DW +: DW]) : b_i[rm][c];
                    a_q[r][c] <= aq; a_i[r][c] <= ai; a_f[r][c] <= f;
                    b_q[r][c] <= bq; b_i[r][c] <= bi;
                    p_q[r][c] <= 48'(aq * bq) + 48'(ai * bi);
                    p_i[r][c] <= 48'(ai * bq) - 48'(aq * bi);
                    p_f[r][c] <= f;
                    if (p_f[r][c]) begin
                        res_q[r][c] <= (acc_q[r][c] + p_q[r][c]) >>> SB;
                        res_i[r][c] <= (acc_i[r][c] + p_i[r][c]) >>> SB;
                        res_v[r][c] <= 1'b1;
                        acc_q[r][c] <= '0;
                        acc_i[r][c] <= '0;
                    end else begin
                        acc_q[r][c] <= acc_q[r][c] + p_q[r][c];
                        acc_i[r][c] <= acc_i[r][c] + p_i[r][c];
                    end
                end
            end
        end
    end

    task automatic test_reset();
        bus.start  = 1'b0;
        bus2.start = 1'b0;
        rst_n      = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
        n_checks++; if (bus.buf_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got %b want 0", bus.buf_rd_en); end
        n_checks++; if (bus.buf_rd_addr !== '0) begin n_fail++; $display("FAIL reset_addr got %h want 0", bus.buf_rd_addr); end
        n_checks++; if (bus.feed_q !== '0) begin n_fail++; $display("FAIL reset_feed_q got %h want 0", bus.feed_q); end
        n_checks++; if (bus.feed_i !== '0) begin n_fail++; $display("FAIL reset_feed_i got %h want 0", bus.feed_i); end
        n_checks++; if (bus.fin_lane !== '0) begin n_fail++; $display("FAIL reset_fin got %b want 0", bus.fin_lane); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0 || bus.buf_rd_en !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset busy=%b rd_en=%b want 0 0", bus.busy, bus.buf_rd_en); end
    endtask

    task automatic test_main_run();
        logic [N*DW-1:0] eq, ei;
        logic [N-1:0]    ef;
        int s;
        mode = 0;
        @(negedge clk);
        bus.start = 1'b1;
        for (int t = 1; t <= 30; t++) begin
            @(negedge clk);
            bus.start = 1'b0;
            eq = '0; ei = '0; ef = '0;
            for (int k = 0; k < N; k++) begin
                s = t - 2 - k;
                if (s >= 0 && s < S) begin
                    eq[k*DW +: DW] = DW'(16 * k + s);
                    ei[k*DW +: DW] = DW'(-(16 * k + s));
                end
                if (t == S + 1 + k) ef[k] = 1'b1;
            end
            n_checks++; if (bus.buf_rd_en !== (t >= 1 && t <= S)) begin n_fail++; $display("FAIL main_rd_en cycle %0d got %b", t, bus.buf_rd_en); end
            n_checks++; if (bus.buf_rd_addr !== ((t >= 1 && t <= S) ? SB'(t - 1) : SB'(0))) begin n_fail++; $display("FAIL main_addr cycle %0d got %0d", t, bus.buf_rd_addr); end
            n_checks++; if (bus.busy !== (t >= 1 && t <= 24)) begin n_fail++; $display("FAIL main_busy cycle %0d got %b", t, bus.busy); end
            n_checks++; if (bus.done !== (t == 25)) begin n_fail++; $display("FAIL main_done cycle %0d got %b", t, bus.done); end
            n_checks++; if (bus.fin_lane !== ef) begin n_fail++; $display("FAIL main_fin cycle %0d got %b want %b", t, bus.fin_lane, ef); end
            n_checks++; if (bus.feed_q !== eq) begin n_fail++; $display("FAIL main_feed_q cycle %0d got %h want %h", t, bus.feed_q, eq); end
            n_checks++; if (bus.feed_i !== ei) begin n_fail++; $display("FAIL main_feed_i cycle %0d got %h want %h", t, bus.feed_i, ei); end
        end
    endtask

    task automatic test_back_to_back();
        int reads = 0, dones = 0, rises = 0;
        int done_cyc [2];
        int rise_cyc [2];
        logic prev_busy;
        done_cyc = '{-1, -1};
        rise_cyc = '{-1, -1};
        @(negedge clk);
        prev_busy = bus.busy;
        bus.start = 1'b1;
        for (int t = 1; t <= 60; t++) begin
            @(negedge clk);
            if (t == 40) bus.start = 1'b0;
            if (bus.buf_rd_en) reads++;
            if (bus.done) begin
                if (dones < 2) done_cyc[dones] = t;
                dones++;
            end
            if (bus.busy && !prev_busy) begin
                if (rises < 2) rise_cyc[rises] = t;
                rises++;
            end
            prev_busy = bus.busy;
        end
        bus.start = 1'b0;
        n_checks++; if (reads !== 32) begin n_fail++; $display("FAIL b2b_reads got %0d want 32", reads); end
        n_checks++; if (dones !== 2) begin n_fail++; $display("FAIL b2b_dones got %0d want 2", dones); end
        n_checks++; if (done_cyc[0] !== 25 || done_cyc[1] !== 51) begin n_fail++; $display("FAIL b2b_done_cycles got %0d %0d want 25 51", done_cyc[0], done_cyc[1]); end
        n_checks++; if (rises !== 2 || rise_cyc[0] !== 1 || rise_cyc[1] !== 27) begin n_fail++; $display("FAIL b2b_accept got n=%0d at %0d %0d want 2 at 1 27", rises, rise_cyc[0], rise_cyc[1]); end
    endtask

    task automatic test_reset_mid();
        int dones = 0, busys = 0, bad_addr = 0, done_at = -1;
        @(negedge clk);
        bus.start = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        n_checks++; if (bus.feed_q === '0) begin n_fail++; $display("FAIL midrst_pre_feed got %h want nonzero", bus.feed_q); end
        rst_n = 1'b0;
        #1;
        n_checks++; if ({bus.busy, bus.done, bus.buf_rd_en} !== 3'b000) begin n_fail++; $display("FAIL midrst_ctrl got %b want 000", {bus.busy, bus.done, bus.buf_rd_en}); end
        n_checks++; if (bus.buf_rd_addr !== '0 || bus.fin_lane !== '0) begin n_fail++; $display("FAIL midrst_addr_fin got %h %b want 0 0", bus.buf_rd_addr, bus.fin_lane); end
        n_checks++; if (bus.feed_q !== '0 || bus.feed_i !== '0) begin n_fail++; $display("FAIL midrst_feed got %h %h want 0 0", bus.feed_q, bus.feed_i); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (bus.done) dones++;
            if (bus.busy) busys++;
        end
        n_checks++; if (dones !== 0 || busys !== 0) begin n_fail++; $display("FAIL midrst_no_done got done=%0d busy=%0d want 0 0", dones, busys); end
        @(negedge clk);
        bus.start = 1'b1;
        for (int t = 1; t <= 27; t++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (t <= S && (bus.buf_rd_en !== 1'b1 || bus.buf_rd_addr !== SB'(t - 1))) bad_addr++;
            if (bus.done && done_at < 0) done_at = t;
        end
        n_checks++; if (bad_addr !== 0) begin n_fail++; $display("FAIL midrst_rerun_addr got %0d bad cycles want 0", bad_addr); end
        n_checks++; if (done_at !== 25) begin n_fail++; $display("FAIL midrst_rerun_done got cycle %0d want 25", done_at); end
    endtask

    task automatic test_end_to_end();
        mode = 1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.start = 1'b1;
        for (int t = 1; t <= 25; t++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (t == 24) begin
                n_checks++; if (res_v[N-1][N-1] !== 1'b0) begin n_fail++; $display("FAIL e2e_last_pe_early got %b want 0", res_v[N-1][N-1]); end
            end
        end
        n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL e2e_done got %b want 1", bus.done); end
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                n_checks++; if (res_v[r][c] !== 1'b1) begin n_fail++; $display("FAIL e2e_valid pe(%0d,%0d) got %b want 1", r, c, res_v[r][c]); end
                n_checks++; if (res_q[r][c] !== 48'((r + 1) * (c + 1))) begin n_fail++; $display("FAIL e2e_q pe(%0d,%0d) got %0d want %0d", r, c, res_q[r][c], (r + 1) * (c + 1)); end
                n_checks++; if (res_i[r][c] !== 48'sd0) begin n_fail++; $display("FAIL e2e_i pe(%0d,%0d) got %0d want 0", r, c, res_i[r][c]); end
            end
        end
        repeat (3) @(negedge clk);
        mode = 0;
    endtask

    task automatic test_small_params();
        logic [1:0] ef;
        @(negedge clk);
        bus2.start = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            bus2.start = 1'b0;
            ef = (t == 3) ? 2'b01 : (t == 4) ? 2'b10 : 2'b00;
            n_checks++; if (bus2.done !== (t == 7)) begin n_fail++; $display("FAIL small_done cycle %0d got %b", t, bus2.done); end
            n_checks++; if (bus2.fin_lane !== ef) begin n_fail++; $display("FAIL small_fin cycle %0d got %b want %b", t, bus2.fin_lane, ef); end
            n_checks++; if (bus2.busy !== (t >= 1 && t <= 6)) begin n_fail++; $display("FAIL small_busy cycle %0d got %b", t, bus2.busy); end
            n_checks++; if (bus2.buf_rd_en !== (t == 1 || t == 2)) begin n_fail++; $display("FAIL small_rd_en cycle %0d got %b", t, bus2.buf_rd_en); end
        end
    endtask

    initial begin
        test_reset();
        test_main_run();
        test_back_to_back();
        test_reset_mid();
        test_end_to_end();
        test_small_params();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cov_array_feed_ctrl.md
Name: cov_array_feed_ctrl

Overview:
- Sequencer for the N×N systolic covariance array built from two-stage off-diagonal PEs (a from left, b from top, finish flag, result = acc >>> SAMPLES_BITS).
- On start, reads 2^SAMPLES_BITS complex snapshots (N antennas each) from a sample buffer with 1-cycle read latency.
- Skews each antenna lane so row/column k lags lane 0 by k cycles, drives a zero-filled feed, and issues per-lane finish flags on the last sample.
- Pulses done when the last PE's result is registered.

Parameters:
- N_ANT, 4, array dimension / antenna count (2..16)
- DATA_WIDTH, 16, signed width of each I or Q sample
- SAMPLES_BITS, 4, log2 of snapshots per covariance estimate (S = 2^SAMPLES_BITS)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request one covariance run; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when all array results are valid
- buf_rd_en  out  1  sample buffer read strobe
- buf_rd_addr  out  SAMPLES_BITS  snapshot address
- buf_rd_data  in  N_ANT*2*DATA_WIDTH  snapshot returned 1 cycle after buf_rd_en; lane k = {q,i} at bits [(2k+2)*DW-1 : 2k*DW]
- feed_q  out  N_ANT*DATA_WIDTH  skewed Q per lane; drives row-k a input and column-k b input
- feed_i  out  N_ANT*DATA_WIDTH  skewed I per lane, same mapping
- fin_lane  out  N_ANT  finish flag per lane, aligned with that lane's last sample

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, buf_rd_en, fin_lane = 0; buf_rd_addr = 0; feed_q, feed_i and all skew registers = 0.
- Timing is relative to cycle 0, the IDLE cycle in which start=1 is sampled.
- FSM: IDLE -> READ (start=1) -> DRAIN (after S reads) -> DONE (counter hits end) -> IDLE.
- READ: cycles 1..S; buf_rd_en=1; buf_rd_addr = 0,1,...,S-1; address counter wraps to 0 on exit.
- Snapshot s returns from the buffer in cycle s+2 and is captured into a lane-0 stage register.
- Lane k adds k further register stages. Lane k presents sample s on feed_* during cycle s+2+k, for s = 0..S-1.
- Outside its valid window each lane drives exactly 0, so PE accumulators see zero products.
- fin_lane[k] = 1 only in cycle S+1+k, the same cycle as lane k's sample S-1. Each flag is a single-cycle pulse.
- Array contract: PE(r,c) sees its last sample and finish at cycle S+1+r+c. Its result registers at cycle S+3+r+c.
- DRAIN: a single cycle counter runs from the start of READ. It ends at cycle S+2*N_ANT.
- DONE: done=1 for exactly one cycle, at cycle S+2*N_ANT+1 (= S+3+2(N_ANT-1)). busy=0 in that same cycle; return to IDLE.
- busy=1 in cycles 1..S+2*N_ANT.
- start while busy or during DONE: ignored, not queued.
- start in IDLE the cycle after done: accepted normally. The new run's feed windows never overlap the previous run's zero tail.
- Reset asserted mid-run: immediate return to reset values; no done; the partial run is discarded. The array is reset by the same rst_n.
- Counter width: ceil(log2(S+2*N_ANT+2)) bits; no overflow for legal parameters.
- Data is passed through unmodified; no arithmetic. Conjugation and scaling happen in the PEs.

Test Plan:
- N_ANT=4, S=16, buffer word s lane k = {q=16*k+s, i=-(16*k+s)}, start at cycle 0 → buf_rd_addr 0..15 in cycles 1..16; lane 2 shows q=32..47 in cycles 4..19 and 0 elsewhere.
- Same run → fin_lane = 0001,0010,0100,1000 in cycles 17,18,19,20 only; done=1 only in cycle 25; busy high in cycles 1..24.
- start held high continuously → runs accepted at cycle 0 and cycle 26 only; each run has exactly 16 reads and one done pulse.
- rst_n low at cycle 10 (mid-READ) for 2 cycles → all outputs 0 immediately. No done appears. The next start after release produces a clean full run with addresses from 0.
- End-to-end with a 4×4 PE array model, all snapshots lane k = (k+1, 0) → PE(r,c) result_q = (r+1)(c+1)*16 >>> 4 = (r+1)(c+1); result_i = 0; all results valid by the done cycle.
- Parameter sweep N_ANT=2, SAMPLES_BITS=1 → done at cycle 7; fin_lane pulses at cycles 3 and 4.
